// File: rtl/pulse_cmd_pkg.sv
// Shared types for the pulse command execution stage: the latched command
// word, the impulse modulation types and the execution FSM states.
package pulse_cmd_pkg;

  localparam int unsigned TW_DEF      = 48;
  localparam int unsigned REQ_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IMP_FIXED     = 2'd0,
    IMP_SWEEP     = 2'd1,
    IMP_STEP      = 2'd2,
    IMP_FIXED_ALT = 2'd3
  } impulse_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_DONE
  } exec_state_t;

  // 338-bit command word, start time in the MSBs.
  typedef struct packed {
    logic [63:0]       time_start;
    logic [TW_DEF-1:0] freq;
    logic [TW_DEF-1:0] freq_step;
    logic [31:0]       freq_rate;
    logic [15:0]       n_impuls;
    impulse_t          ptype;
    logic [31:0]       ti;
    logic [31:0]       tp;
    logic [31:0]       tb1;
    logic [31:0]       tb2;
  } cmd_t;

endpackage

// File: rtl/freq_sweep.sv
// Tuning-word accumulator: reloads on load, adds step on step_now, or adds
// step every max(rate,1) enabled cycles with the first enabled cycle at base.
module freq_sweep #(
  parameter int unsigned TW = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] base,
  input  logic [TW-1:0] step,
  input  logic [31:0]   rate,
  input  logic          enable,
  input  logic          step_now,
  output logic [TW-1:0] tw
);

  logic [31:0]   rate_last;
  logic [31:0]   rcnt;
  logic [31:0]   rcnt_base;
  logic          started;
  logic          started_base;
  logic [TW-1:0] tw_base;

  assign rate_last = (rate == 32'd0) ? 32'd0 : rate - 32'd1;

  // A load in the same cycle as the first enabled cycle must still count
  // that cycle, so the enable path works from the post-load values.
  always_comb begin
    tw_base      = load ? base : tw;
    rcnt_base    = load ? 32'd0 : rcnt;
    started_base = load ? 1'b0 : started;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tw      <= '0;
      rcnt    <= '0;
      started <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments, so the later
      // assignments below override the defaults without ordering hazards.
      tw      <= tw_base;
      rcnt    <= rcnt_base;
      started <= started_base;
      if (step_now) begin
        tw <= tw_base + step;
      end else if (enable) begin
        started <= 1'b1;
        rcnt    <= (rcnt_base == rate_last) ? 32'd0 : rcnt_base + 32'd1;
        if (started_base && (rcnt_base == 32'd0)) tw <= tw_base + step;
      end
    end
  end

endmodule

// File: rtl/pulse_cmd_exec.sv
// Pulse command execution stage: latches a command, waits for its start time,
// emits N impulse periods with gates and tuning word, then requests the next.
module pulse_cmd_exec
  import pulse_cmd_pkg::*;
#(
  parameter int unsigned REQ_LEN = REQ_LEN_DEF,
  parameter int unsigned TW      = TW_DEF
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic [63:0]   TIME,
  input  logic          DATA_WR,
  input  logic [TW-1:0] FREQ_z,
  input  logic [TW-1:0] FREQ_STEP_z,
  input  logic [31:0]   FREQ_RATE_z,
  input  logic [63:0]   TIME_START_z,
  input  logic [15:0]   N_impuls_z,
  input  logic [1:0]    TYPE_impulse_z,
  input  logic [31:0]   Interval_Ti_z,
  input  logic [31:0]   Interval_Tp_z,
  input  logic [31:0]   Tblank1_z,
  input  logic [31:0]   Tblank2_z,
  output logic          IMP,
  output logic          BLANK,
  output logic [TW-1:0] FREQ_OUT,
  output logic          BUSY,
  output logic          REQ_COMM,
  output logic          CMD_DROP,
  output logic [15:0]   PULSE_CNT
);

  localparam int unsigned DCW = (REQ_LEN > 1) ? $clog2(REQ_LEN) : 1;

  exec_state_t    state, state_nx;
  cmd_t           cmd, cmd_in;
  logic [31:0]    pc;
  logic [15:0]    k;
  logic [DCW-1:0] done_cnt;
  logic           imp_q, blank_q, drop_q;

  logic        latch, period_end, last_pulse, time_hit, req_last;
  logic [31:0] tp_eff;
  logic [33:0] edge_a, edge_b, edge_c, pc_w;
  logic        imp_now, blank_now;
  logic        fs_load, fs_step_now, fs_enable;

  assign cmd_in = '{
    time_start: TIME_START_z,
    freq:       FREQ_z,
    freq_step:  FREQ_STEP_z,
    freq_rate:  FREQ_RATE_z,
    n_impuls:   N_impuls_z,
    ptype:      impulse_t'(TYPE_impulse_z),
    ti:         Interval_Ti_z,
    tp:         Interval_Tp_z,
    tb1:        Tblank1_z,
    tb2:        Tblank2_z
  };

  assign latch      = DATA_WR && (state == S_IDLE || state == S_ARMED);
  assign tp_eff     = (cmd.tp == 32'd0) ? 32'd1 : cmd.tp;
  assign period_end = (pc == tp_eff - 32'd1);
  assign last_pulse = ({1'b0, k} + 17'd1) == {1'b0, cmd.n_impuls};
  assign time_hit   = (TIME >= cmd.time_start);
  assign req_last   = (done_cnt == DCW'(REQ_LEN - 1));

  // Phase edges are widened to 34 bits so Tb1+Ti+Tb2 can never wrap; pc never
  // reaches Tp', which truncates any phase that runs past the period end.
  assign edge_a    = {2'b00, cmd.tb1};
  assign edge_b    = edge_a + {2'b00, cmd.ti};
  assign edge_c    = edge_b + {2'b00, cmd.tb2};
  assign pc_w      = {2'b00, pc};
  assign imp_now   = (pc_w >= edge_a) && (pc_w < edge_b);
  assign blank_now = (pc_w < edge_a) || ((pc_w >= edge_b) && (pc_w < edge_c));

  assign fs_load     = (state == S_RUN) && (pc == 32'd0) &&
                       ((cmd.ptype != IMP_STEP) || (k == 16'd0));
  assign fs_step_now = (state == S_RUN) && (pc == 32'd0) &&
                       (cmd.ptype == IMP_STEP) && (k != 16'd0);
  assign fs_enable   = (state == S_RUN) && (cmd.ptype == IMP_SWEEP) && imp_now;

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      S_IDLE:  if (DATA_WR) state_nx = S_ARMED;
      S_ARMED: if (!DATA_WR && time_hit)
                 state_nx = (cmd.n_impuls == 16'd0) ? S_DONE : S_RUN;
      S_RUN:   if (period_end && last_pulse) state_nx = S_DONE;
      S_DONE:  if (req_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= S_IDLE;
      // NOTE: the command word is a plain register, not a memory, so it is
      // cleared by reset like the rest of the state.
      cmd      <= '0;
      pc       <= '0;
      k        <= '0;
      done_cnt <= '0;
      imp_q    <= 1'b0;
      blank_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      imp_q    <= (state == S_RUN) && imp_now;
      blank_q  <= (state == S_RUN) && blank_now;
      drop_q   <= DATA_WR && (state == S_RUN || state == S_DONE);
      done_cnt <= (state == S_DONE) ? done_cnt + 1'b1 : '0;
      if (latch) begin
        cmd <= cmd_in;
        pc  <= '0;
        k   <= '0;
      end else if (state == S_RUN) begin
        if (period_end) begin
          k <= k + 16'd1;
          if (!last_pulse) pc <= '0;
        end else begin
          pc <= pc + 32'd1;
        end
      end
    end
  end

  freq_sweep #(.TW(TW)) u_freq_sweep (
    .clk      (CLK),
    .rst      (rst),
    .load     (fs_load),
    .base     (cmd.freq),
    .step     (cmd.freq_step),
    .rate     (cmd.freq_rate),
    .enable   (fs_enable),
    .step_now (fs_step_now),
    .tw       (FREQ_OUT)
  );

  assign IMP       = imp_q;
  assign BLANK     = blank_q;
  assign BUSY      = (state != S_IDLE);
  assign REQ_COMM  = (state == S_DONE);
  assign CMD_DROP  = drop_q;
  assign PULSE_CNT = k;

endmodule

// File: tb/tb_pulse_cmd_exec.sv
// Directed bench for pulse_cmd_exec: each scenario records outputs per cycle
// after the latch and compares them against hand-computed cycle indices.
module tb_pulse_cmd_exec;

  logic        CLK = 1'b0;
  logic        rst;
  logic [63:0] TIME;
  logic        DATA_WR;
  logic [47:0] FREQ_z, FREQ_STEP_z;
  logic [31:0] FREQ_RATE_z;
  logic [63:0] TIME_START_z;
  logic [15:0] N_impuls_z;
  logic [1:0]  TYPE_impulse_z;
  logic [31:0] Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z;
  logic        IMP, BLANK, BUSY, REQ_COMM, CMD_DROP;
  logic [47:0] FREQ_OUT;
  logic [15:0] PULSE_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rec_imp   [0:299];
  logic        rec_blank [0:299];
  logic        rec_req   [0:299];
  logic        rec_busy  [0:299];
  logic        rec_drop  [0:299];
  logic [47:0] rec_freq  [0:299];
  logic [15:0] rec_pcnt  [0:299];

  pulse_cmd_exec dut (
    .CLK(CLK), .rst(rst), .TIME(TIME), .DATA_WR(DATA_WR),
    .FREQ_z(FREQ_z), .FREQ_STEP_z(FREQ_STEP_z), .FREQ_RATE_z(FREQ_RATE_z),
    .TIME_START_z(TIME_START_z), .N_impuls_z(N_impuls_z),
    .TYPE_impulse_z(TYPE_impulse_z), .Interval_Ti_z(Interval_Ti_z),
    .Interval_Tp_z(Interval_Tp_z), .Tblank1_z(Tblank1_z), .Tblank2_z(Tblank2_z),
    .IMP(IMP), .BLANK(BLANK), .FREQ_OUT(FREQ_OUT), .BUSY(BUSY),
    .REQ_COMM(REQ_COMM), .CMD_DROP(CMD_DROP), .PULSE_CNT(PULSE_CNT)
  );

  always #10 CLK = ~CLK;

  // TIME advances by one per clock; DUT at an edge sees the pre-increment value.
  task automatic tick();
    @(posedge CLK);
    #1;
    TIME = TIME + 64'd1;
  endtask

  task automatic send_cmd(input logic [63:0] start, input logic [47:0] f,
                          input logic [47:0] fs, input logic [31:0] rate,
                          input logic [15:0] n, input logic [1:0] typ,
                          input logic [31:0] ti, input logic [31:0] tp,
                          input logic [31:0] tb1, input logic [31:0] tb2);
    TIME_START_z = start; FREQ_z = f; FREQ_STEP_z = fs; FREQ_RATE_z = rate;
    N_impuls_z = n; TYPE_impulse_z = typ; Interval_Ti_z = ti;
    Interval_Tp_z = tp; Tblank1_z = tb1; Tblank2_z = tb2;
    DATA_WR = 1'b1;
    tick();
    DATA_WR = 1'b0;
  endtask

  // Index 0 is the first cycle after the latch edge.
  task automatic capture(input int n, input int inj_a, input int inj_b);
    for (int i = 0; i < n; i++) begin
      rec_imp[i] = IMP; rec_blank[i] = BLANK; rec_req[i] = REQ_COMM;
      rec_busy[i] = BUSY; rec_drop[i] = CMD_DROP; rec_freq[i] = FREQ_OUT;
      rec_pcnt[i] = PULSE_CNT;
      if (i == inj_a || i == inj_b) DATA_WR = 1'b1;
      tick();
      DATA_WR = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({IMP, BLANK, BUSY, REQ_COMM, CMD_DROP} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {IMP, BLANK, BUSY, REQ_COMM, CMD_DROP});
    end
    n_checks++;
    if (FREQ_OUT !== 48'd0) begin
      n_fail++; $display("FAIL reset_freq: got %0d want 0", FREQ_OUT);
    end
    n_checks++;
    if (PULSE_CNT !== 16'd0) begin
      n_fail++; $display("FAIL reset_pcnt: got %0d want 0", PULSE_CNT);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic e_imp, e_blank, e_req, e_busy;
    send_cmd(TIME + 64'd50, 48'h123456789ABC, 48'd0, 32'd0, 16'd2, 2'd0,
             32'd20, 32'd100, 32'd5, 32'd5);
    capture(260, -1, -1);
    for (int i = 0; i < 260; i++) begin
      e_imp   = (i >= 56 && i <= 75) || (i >= 156 && i <= 175);
      e_blank = (i >= 51 && i <= 55) || (i >= 76 && i <= 80) ||
                (i >= 151 && i <= 155) || (i >= 176 && i <= 180);
      e_req   = (i >= 250 && i <= 253);
      e_busy  = (i <= 253);
      n_checks++;
      if (rec_imp[i] !== e_imp) begin
        n_fail++; $display("FAIL basic_imp[%0d]: got %b want %b", i, rec_imp[i], e_imp);
      end
      n_checks++;
      if (rec_blank[i] !== e_blank) begin
        n_fail++; $display("FAIL basic_blank[%0d]: got %b want %b", i, rec_blank[i], e_blank);
      end
      n_checks++;
      if (rec_req[i] !== e_req) begin
        n_fail++; $display("FAIL basic_req[%0d]: got %b want %b", i, rec_req[i], e_req);
      end
      n_checks++;
      if (rec_busy[i] !== e_busy) begin
        n_fail++; $display("FAIL basic_busy[%0d]: got %b want %b", i, rec_busy[i], e_busy);
      end
    end
    n_checks++;
    if (rec_freq[60] !== 48'h123456789ABC) begin
      n_fail++; $display("FAIL basic_freq: got %h want 123456789abc", rec_freq[60]);
    end
    n_checks++;
    if (rec_pcnt[255] !== 16'd2) begin
      n_fail++; $display("FAIL basic_pcnt: got %0d want 2", rec_pcnt[255]);
    end
  endtask

  task automatic test_sweep();
    logic [47:0] e_f;
    send_cmd(TIME + 64'd10, 48'd1000, 48'd10, 32'd4, 16'd2, 2'd1,
             32'd16, 32'd30, 32'd3, 32'd2);
    capture(80, -1, -1);
    for (int i = 14; i <= 29; i++) begin
      e_f = 48'd1000 + 48'd10 * 48'((i - 14) / 4);
      n_checks++;
      if (rec_freq[i] !== e_f || rec_imp[i] !== 1'b1) begin
        n_fail++; $display("FAIL sweep_p0[%0d]: got %0d imp %b want %0d imp 1", i, rec_freq[i], rec_imp[i], e_f);
      end
    end
    n_checks++;
    if (rec_freq[40] !== 48'd1030) begin
      n_fail++; $display("FAIL sweep_hold: got %0d want 1030", rec_freq[40]);
    end
    for (int i = 41; i <= 47; i++) begin
      n_checks++;
      if (rec_freq[i] !== 48'd1000) begin
        n_fail++; $display("FAIL sweep_reload[%0d]: got %0d want 1000", i, rec_freq[i]);
      end
    end
    n_checks++;
    if (rec_freq[48] !== 48'd1010) begin
      n_fail++; $display("FAIL sweep_p1_step: got %0d want 1010", rec_freq[48]);
    end
    n_checks++;
    if (rec_pcnt[74] !== 16'd2 || rec_busy[74] !== 1'b0 || rec_req[73] !== 1'b1) begin
      n_fail++; $display("FAIL sweep_end: got pcnt %0d busy %b req %b want 2 0 1", rec_pcnt[74], rec_busy[74], rec_req[73]);
    end
  endtask

  task automatic test_per_pulse_step();
    logic [47:0] f0;
    f0 = 48'hFFFF_FFFF_FFFB;
    send_cmd(TIME + 64'd5, f0, 48'd10, 32'd1, 16'd3, 2'd2,
             32'd2, 32'd10, 32'd1, 32'd1);
    capture(45, -1, -1);
    n_checks++;
    if (rec_freq[5] !== 48'd1030) begin
      n_fail++; $display("FAIL step_prehold: got %0d want 1030", rec_freq[5]);
    end
    n_checks++;
    if (rec_freq[7] !== f0) begin
      n_fail++; $display("FAIL step_k0: got %h want %h", rec_freq[7], f0);
    end
    n_checks++;
    if (rec_freq[17] !== 48'd5) begin
      n_fail++; $display("FAIL step_k1_wrap: got %0d want 5", rec_freq[17]);
    end
    n_checks++;
    if (rec_freq[27] !== 48'd15) begin
      n_fail++; $display("FAIL step_k2: got %0d want 15", rec_freq[27]);
    end
    n_checks++;
    if (rec_freq[40] !== 48'd15 || rec_pcnt[40] !== 16'd3) begin
      n_fail++; $display("FAIL step_done: got freq %0d pcnt %0d want 15 3", rec_freq[40], rec_pcnt[40]);
    end

    // N=0: straight to DONE, no impulse, FREQ_OUT untouched.
    send_cmd(TIME + 64'd3, 48'd777, 48'd1, 32'd1, 16'd0, 2'd0,
             32'd5, 32'd10, 32'd1, 32'd1);
    capture(20, -1, -1);
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (rec_req[i] !== (i >= 3 && i <= 6) || rec_imp[i] !== 1'b0 || rec_blank[i] !== 1'b0) begin
        n_fail++; $display("FAIL n0[%0d]: got req %b imp %b blank %b want req %b imp 0 blank 0", i, rec_req[i], rec_imp[i], rec_blank[i], (i >= 3 && i <= 6));
      end
    end
    n_checks++;
    if (rec_freq[10] !== 48'd15 || rec_pcnt[10] !== 16'd0 || rec_busy[7] !== 1'b0) begin
      n_fail++; $display("FAIL n0_end: got freq %0d pcnt %0d busy %b want 15 0 0", rec_freq[10], rec_pcnt[10], rec_busy[7]);
    end
  endtask

  task automatic test_rearm_drop();
    logic e_imp;
    TIME = 64'd400;
    send_cmd(64'd1000, 48'd111, 48'd0, 32'd1, 16'd2, 2'd0, 32'd4, 32'd20, 32'd2, 32'd2);
    tick(); tick();
    send_cmd(64'd500, 48'd222, 48'd0, 32'd1, 16'd2, 2'd0, 32'd4, 32'd20, 32'd2, 32'd2);
    capture(150, 105, 138);
    for (int i = 0; i < 150; i++) begin
      e_imp = (i >= 100 && i <= 103) || (i >= 120 && i <= 123);
      n_checks++;
      if (rec_imp[i] !== e_imp) begin
        n_fail++; $display("FAIL rearm_imp[%0d]: got %b want %b", i, rec_imp[i], e_imp);
      end
      n_checks++;
      if (rec_drop[i] !== (i == 106 || i == 139)) begin
        n_fail++; $display("FAIL drop[%0d]: got %b want %b", i, rec_drop[i], (i == 106 || i == 139));
      end
    end
    n_checks++;
    if (rec_freq[98] !== 48'd222) begin
      n_fail++; $display("FAIL rearm_freq: got %0d want 222", rec_freq[98]);
    end
    n_checks++;
    if (rec_pcnt[141] !== 16'd2 || rec_busy[141] !== 1'b0 || rec_busy[149] !== 1'b0 || rec_req[140] !== 1'b1) begin
      n_fail++; $display("FAIL rearm_end: got pcnt %0d busy %b/%b req %b want 2 0/0 1", rec_pcnt[141], rec_busy[141], rec_busy[149], rec_req[140]);
    end
  endtask

  task automatic test_edge_cases();
    send_cmd(64'd0, 48'd5, 48'd0, 32'd0, 16'd4, 2'd0, 32'd0, 32'd0, 32'd0, 32'd3);
    capture(12, -1, -1);
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (rec_imp[i] !== 1'b0 || rec_blank[i] !== (i >= 2 && i <= 5)) begin
        n_fail++; $display("FAIL tp0_gates[%0d]: got imp %b blank %b want 0 %b", i, rec_imp[i], rec_blank[i], (i >= 2 && i <= 5));
      end
    end
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (rec_pcnt[i] !== 16'(i - 1)) begin
        n_fail++; $display("FAIL tp0_pcnt[%0d]: got %0d want %0d", i, rec_pcnt[i], i - 1);
      end
    end
    n_checks++;
    if (rec_req[5] !== 1'b1 || rec_req[8] !== 1'b1 || rec_busy[9] !== 1'b0) begin
      n_fail++; $display("FAIL tp0_done: got req %b/%b busy %b want 1/1 0", rec_req[5], rec_req[8], rec_busy[9]);
    end
  endtask

  task automatic test_time_jump();
    int imp_seen;
    bit got_req;
    TIME = 64'd2000;
    send_cmd(64'd2005, 48'd9, 48'd0, 32'd1, 16'd1, 2'd0, 32'd1, 32'd4, 32'd1, 32'd0);
    tick(); tick();
    TIME = 64'd100;
    for (int i = 0; i < 30; i++) begin
      n_checks++;
      if (BUSY !== 1'b1 || IMP !== 1'b0 || BLANK !== 1'b0) begin
        n_fail++; $display("FAIL jump_wait[%0d]: got busy %b imp %b blank %b want 1 0 0", i, BUSY, IMP, BLANK);
      end
      tick();
    end
    TIME = 64'd5000;
    imp_seen = 0;
    got_req  = 1'b0;
    for (int i = 0; i < 20 && !got_req; i++) begin
      if (IMP === 1'b1) imp_seen++;
      if (REQ_COMM === 1'b1) got_req = 1'b1;
      else tick();
    end
    n_checks++;
    if (!got_req || imp_seen != 1) begin
      n_fail++; $display("FAIL jump_run: got req %b imp_cycles %0d want 1 1", got_req, imp_seen);
    end
    repeat (6) tick();
  endtask

  task automatic test_reset_mid_run();
    send_cmd(64'd0, 48'd3, 48'd0, 32'd1, 16'd5, 2'd0, 32'd40, 32'd50, 32'd0, 32'd0);
    repeat (10) tick();
    n_checks++;
    if (IMP !== 1'b1 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL midrun_active: got imp %b busy %b want 1 1", IMP, BUSY);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({IMP, BLANK, REQ_COMM, BUSY} !== 4'b0 || PULSE_CNT !== 16'd0) begin
      n_fail++; $display("FAIL midrun_reset: got %b pcnt %0d want 0000 0", {IMP, BLANK, REQ_COMM, BUSY}, PULSE_CNT);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (REQ_COMM !== 1'b0 || BUSY !== 1'b0 || IMP !== 1'b0) begin
        n_fail++; $display("FAIL midrun_after[%0d]: got req %b busy %b imp %b want 0 0 0", i, REQ_COMM, BUSY, IMP);
      end
    end
  endtask

  initial begin
    rst = 1'b1; TIME = 64'd0; DATA_WR = 1'b0;
    FREQ_z = '0; FREQ_STEP_z = '0; FREQ_RATE_z = '0; TIME_START_z = '0;
    N_impuls_z = '0; TYPE_impulse_z = '0; Interval_Ti_z = '0;
    Interval_Tp_z = '0; Tblank1_z = '0; Tblank2_z = '0;
    test_reset();
    test_basic();
    test_sweep();
    test_per_pulse_step();
    test_rearm_drop();
    test_edge_cases();
    test_time_jump();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
